assoc_cache: RTL
================

# assoc_cache

Parametrised set-associative, write-back, write-allocate cache sitting between a core load/store port and the Wishbone bus; successor to the direct-lookup instruction cache prototype. Adds N-way sets with per-set replacement, full byte-enable writes, dirty-line write-back, and a whole-cache flush. All bus traffic goes through the existing `lsu`, one 32-bit word per transfer.

## Interface
- `N_SETS`, 8: number of sets, power of two, ≥2.
- `N_WAYS`, 2: ways per set, power of two, 1–8.
- `N_WORDS_PER_LINE`, 8: 32-bit words per line, power of two, ≥2.
- Derived: `OFF_W = clog2(N_WORDS_PER_LINE)+2`, `IDX_W = clog2(N_SETS)`, `TAG_W = 32-OFF_W-IDX_W`.

- `clk` in 1: single clock.
- `rstn_i` in 1: asynchronous, active-low reset.
- `read_i` in 1: load request, held until `valid_o`.
- `write_i` in 1: store request, held until `valid_o`; `read_i` and `write_i` never both high.
- `we_i` in 4: byte enables for stores, any pattern legal.
- `addr_i` in 32: byte address; bits [1:0] ignored.
- `data_i` in 32: store data, byte lanes aligned to `we_i`.
- `data_o` out 32: load data, valid only with `valid_o`.
- `valid_o` out 1: request completed this cycle.
- `flush_i` in 1: single-cycle pulse; write back all dirty lines, invalidate all.
- `busy_o` out 1: miss handling or flush in progress.
- `wb_bus` `wb_bus_t.master`: Wishbone master, driven by internal `lsu`.

## Operation
- Address split: tag = `addr_i[31:OFF_W+IDX_W]`, index = `addr_i[OFF_W+IDX_W-1:OFF_W]`, word = `addr_i[OFF_W-1:2]`.
- FSM states: IDLE, WB (write-back victim), REFILL, FLUSH_WB, FLUSH_NEXT.
- IDLE, hit (valid way with matching tag): `valid_o`=1 combinationally; load returns selected word; store merges only bytes with `we_i[b]`=1 and sets dirty.
- IDLE, miss: choose victim = lowest-index invalid way, else set's round-robin pointer. Dirty victim → WB; else → REFILL.
- WB: write words 0..N-1 of victim to `{victim_tag, index, cnt, 2'b00}` with `we`=4'hf; after word N-1 acknowledged → REFILL.
- REFILL: read words 0..N-1 from `{tag, index, cnt, 2'b00}` into a line buffer; after last word, install line (valid=1, dirty=0, new tag), advance that set's pointer (mod `N_WAYS`) only if the victim was valid, return to IDLE. Request then hits on the following cycle.
- `flush_i` in IDLE with no request pending → FLUSH_WB scanning sets 0..N_SETS-1, ways 0..N_WAYS-1; dirty lines written back as in WB; every line invalidated; FLUSH_NEXT advances scan; after last line → IDLE. `flush_i` while busy or with a request present in IDLE is ignored.
- Requests are not accepted (no `valid_o`) while not in IDLE.
- Word counter width `clog2(N_WORDS_PER_LINE)`, wraps to 0 at line end; bus errors are not handled.

## Timing
- Reset: all lines invalid and clean, RR pointers 0, state IDLE, counters 0; `valid_o`=0, `data_o`=0, `busy_o`=0.
- Hit latency: 0 cycles (same cycle as request).
- Clean miss: N lsu reads + 1 install cycle, then hit.
- Dirty miss: N lsu writes + N lsu reads + 1 install cycle.
- `busy_o` high from the cycle after miss detect/flush accept until the cycle state returns to IDLE.
- Requester dropping request mid-miss: refill still completes and installs; no `valid_o`.
- Reset mid-transfer: aborts immediately; cache contents lost (no write-back).

## Structure
- `cache_pkg`: state enum, `cache_meta_t` (valid, dirty, tag), address-field width helper functions.
- One sub-module `cache_set` (per set: `N_WAYS` data lines, metadata, RR pointer, hit compare, byte-merge write); instantiated `N_SETS` times. Reuse existing `lsu` unchanged.

## Test plan
- Reset, read 0x100 (memory word 0xDEADBEEF) → 8 bus reads 0x100–0x11C, then `valid_o`, `data_o`=0xDEADBEEF; repeat read hits with no bus traffic.
- Write 0x104, `we_i`=4'b0110, `data_i`=0x11223344 onto 0xAABBCCDD → read back 0xAA2233DD.
- 2-way, fill set with 0x000 and 0x100 (N_SETS=8, line 32B → same set), dirty way 0, access 0x200 → 8 writes of old line to 0x000–0x01C then 8 reads 0x200–0x21C.
- Three conflicting clean addresses in one set → evictions alternate way 0, way 1, way 0 (RR pointer wrap).
- Dirty 3 lines, pulse `flush_i` → exactly 24 bus writes, `busy_o` high throughout, then every access misses.
- Assert `rstn_i` low during WB word 3 → outputs zero immediately, next read of written address misses and refills from memory.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared state codes, line metadata and address helpers
// for the set-associative write-back cache.
package cache_pkg;

  // widest tag any legal geometry can produce (1 set bit, 2 words/line)
  localparam int TAG_MAX = 28;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_WB         = 3'd1;
  localparam state_t ST_REFILL     = 3'd2;
  localparam state_t ST_FLUSH_WB   = 3'd3;
  localparam state_t ST_FLUSH_NEXT = 3'd4;

  typedef struct packed {
    logic               valid;
    logic               dirty;
    logic [TAG_MAX-1:0] tag;
  } cache_meta_t;

  function automatic int f_off_w(input int n_words);
    return $clog2(n_words) + 2;
  endfunction

  function automatic int f_idx_w(input int n_sets);
    return $clog2(n_sets);
  endfunction

  function automatic int f_tag_w(input int n_sets, input int n_words);
    return 32 - f_off_w(n_words) - f_idx_w(n_sets);
  endfunction

endpackage

// File: rtl/wb_bus_t.sv
// wb_bus_t: classic single-word Wishbone link between the lsu
// and the memory system.
interface wb_bus_t;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m2s;
  logic [31:0] dat_s2m;
  logic        ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_m2s,
    input  ack, dat_s2m
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_m2s,
    output ack, dat_s2m
  );
endinterface

// File: rtl/cache_set.sv
// cache_set: the ways of one set with metadata, round-robin pointer,
// tag compare, byte-merge store and whole-line install.
module cache_set
  import cache_pkg::*;
#(
  parameter int N_WAYS  = 2,
  parameter int N_WORDS = 8,
  parameter int WAY_W   = 1,
  parameter int CNT_W   = 3
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic [TAG_MAX-1:0]    i_tag,
  input  logic [CNT_W-1:0]      i_word,
  input  logic [WAY_W-1:0]      i_sel_way,
  input  logic [CNT_W-1:0]      i_sel_word,
  input  logic                  i_st_en,
  input  logic [3:0]            i_we,
  input  logic [31:0]           i_wdata,
  input  logic                  i_inst_en,
  input  logic                  i_adv,
  input  logic [N_WORDS*32-1:0] i_line,
  input  logic                  i_inv_en,
  output logic                  o_hit,
  output logic [31:0]           o_hit_data,
  output logic [WAY_W-1:0]      o_vic_way,
  output cache_meta_t           o_vic_meta,
  output cache_meta_t           o_sel_meta,
  output logic [31:0]           o_sel_data
);

  cache_meta_t      r_meta [N_WAYS];
  logic [31:0]      r_data [N_WAYS][N_WORDS];
  logic [WAY_W-1:0] r_rr;
  logic [WAY_W-1:0] w_hit_way;
  logic [WAY_W-1:0] w_vic_way;
  logic             w_found;

  // tag compare across all ways
  always_comb begin
    o_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < N_WAYS; w++) begin
      if (r_meta[w].valid && (r_meta[w].tag == i_tag)) begin
        o_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // victim: lowest invalid way, otherwise the round-robin pointer
  always_comb begin
    w_vic_way = r_rr;
    w_found   = 1'b0;
    for (int w = 0; w < N_WAYS; w++) begin
      if (!r_meta[w].valid && !w_found) begin
        w_vic_way = WAY_W'(w);
        w_found   = 1'b1;
      end
    end
  end

  assign o_vic_way  = w_vic_way;
  assign o_vic_meta = r_meta[w_vic_way];
  assign o_sel_meta = r_meta[i_sel_way];
  assign o_hit_data = r_data[w_hit_way][i_word];
  assign o_sel_data = r_data[i_sel_way][i_sel_word];

  // metadata and replacement pointer; cleared by reset
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int w = 0; w < N_WAYS; w++) begin
        r_meta[w] <= '0;
      end
      r_rr <= '0;
    end else begin
      if (i_st_en) begin
        r_meta[w_hit_way].dirty <= 1'b1;
      end
      if (i_inst_en) begin
        r_meta[i_sel_way].valid <= 1'b1;
        r_meta[i_sel_way].dirty <= 1'b0;
        r_meta[i_sel_way].tag   <= i_tag;
        if (i_adv) begin
          r_rr <= (r_rr == WAY_W'(N_WAYS - 1)) ? '0 : r_rr + 1'b1;
        end
      end
      if (i_inv_en) begin
        r_meta[i_sel_way] <= '0;
      end
    end
  end

  // line storage: byte-merged store hits and whole-line installs
  always_ff @(posedge clk) begin
    if (i_st_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) begin
          r_data[w_hit_way][i_word][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    if (i_inst_en) begin
      for (int k = 0; k < N_WORDS; k++) begin
        r_data[i_sel_way][k] <= i_line[32*k +: 32];
      end
    end
  end

endmodule

// File: rtl/lsu.sv
// lsu: one Wishbone word transfer per accepted request; the request
// is latched so the bus stays stable until ack.
module lsu (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [3:0]  i_sel,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_wdat,
  output logic        o_done,
  output logic [31:0] o_rdat,
  wb_bus_t.master     wb
);

  logic        r_busy;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;

  assign wb.cyc     = r_busy;
  assign wb.stb     = r_busy;
  assign wb.we      = r_we;
  assign wb.sel     = r_sel;
  assign wb.adr     = r_adr;
  assign wb.dat_m2s = r_dat;

  assign o_done = r_busy & wb.ack;
  assign o_rdat = wb.dat_s2m;

  // accept a new word only when idle; drop the strobe on ack
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_busy <= 1'b0;
      r_we   <= 1'b0;
      r_sel  <= '0;
      r_adr  <= '0;
      r_dat  <= '0;
    end else if (!r_busy) begin
      if (i_req) begin
        r_busy <= 1'b1;
        r_we   <= i_we;
        r_sel  <= i_sel;
        r_adr  <= i_adr;
        r_dat  <= i_wdat;
      end
    end else if (wb.ack) begin
      r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: set-associative write-back, write-allocate cache with
// flush; all bus words move through a single lsu.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int N_SETS           = 8,
  parameter int N_WAYS           = 2,
  parameter int N_WORDS_PER_LINE = 8
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        flush_i,
  output logic        busy_o,
  wb_bus_t.master     wb_bus
);

  localparam int OFF_W = f_off_w(N_WORDS_PER_LINE);
  localparam int IDX_W = f_idx_w(N_SETS);
  localparam int TAG_W = f_tag_w(N_SETS, N_WORDS_PER_LINE);
  localparam int CNT_W = $clog2(N_WORDS_PER_LINE);
  localparam int WAY_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
  localparam int LINE_W = N_WORDS_PER_LINE * 32;

  function automatic logic [31:0] f_adr(
    input logic [TAG_MAX-1:0] t,
    input logic [IDX_W-1:0]   ix,
    input logic [CNT_W-1:0]   c
  );
    return (32'(t) << (OFF_W + IDX_W)) | (32'(ix) << OFF_W) | (32'(c) << 2);
  endfunction

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [TAG_MAX-1:0] r_tag;
  logic [WAY_W-1:0]   r_vic_way;
  logic [TAG_MAX-1:0] r_vic_tag;
  logic               r_vic_valid;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_fill_done;
  logic [IDX_W-1:0]   r_fl_set;
  logic [WAY_W-1:0]   r_fl_way;
  logic [LINE_W-1:0]  r_line;

  logic [TAG_MAX-1:0] w_a_tag;
  logic [IDX_W-1:0]   w_a_idx;
  logic [CNT_W-1:0]   w_a_word;
  logic               w_idle;
  logic               w_in_fl;
  logic               w_req;
  logic [IDX_W-1:0]   w_set;
  logic [TAG_MAX-1:0] w_tag;
  logic [WAY_W-1:0]   w_sel_way;
  logic               w_hit;
  logic               w_hit_now;
  logic               w_st_en;
  logic               w_inst_en;
  logic               w_inv_en;
  logic               w_last;
  logic               w_fl_dirty;
  logic [31:0]        w_hit_data;
  logic [WAY_W-1:0]   w_vic_way;
  cache_meta_t        w_vic_meta;
  cache_meta_t        w_sel_meta;
  logic [31:0]        w_sel_data;
  logic               w_lsu_req;
  logic               w_lsu_we;
  logic [31:0]        w_lsu_adr;
  logic               w_lsu_done;
  logic [31:0]        w_lsu_rdat;

  logic               w_hit_v   [N_SETS];
  logic [31:0]        w_hdat_v  [N_SETS];
  logic [WAY_W-1:0]   w_vway_v  [N_SETS];
  cache_meta_t        w_vmeta_v [N_SETS];
  cache_meta_t        w_smeta_v [N_SETS];
  logic [31:0]        w_sdat_v  [N_SETS];

  assign w_a_tag  = TAG_MAX'(addr_i[31:OFF_W+IDX_W]);
  assign w_a_idx  = addr_i[OFF_W+IDX_W-1:OFF_W];
  assign w_a_word = addr_i[OFF_W-1:2];

  assign w_idle  = (r_state == ST_IDLE);
  assign w_in_fl = (r_state == ST_FLUSH_WB) | (r_state == ST_FLUSH_NEXT);
  assign w_req   = read_i | write_i;

  // set/tag steering: live address in IDLE, latched miss or scan otherwise
  always_comb begin
    w_set = r_idx;
    w_tag = r_tag;
    unique case (1'b1)
      w_idle: begin
        w_set = w_a_idx;
        w_tag = w_a_tag;
      end
      w_in_fl: w_set = r_fl_set;
      default: ;
    endcase
  end

  assign w_sel_way = w_in_fl ? r_fl_way : r_vic_way;

  for (genvar s = 0; s < N_SETS; s++) begin : g_set
    cache_set #(
      .N_WAYS  (N_WAYS),
      .N_WORDS (N_WORDS_PER_LINE),
      .WAY_W   (WAY_W),
      .CNT_W   (CNT_W)
    ) u_set (
      .clk        (clk),
      .rstn_i     (rstn_i),
      .i_tag      (w_tag),
      .i_word     (w_a_word),
      .i_sel_way  (w_sel_way),
      .i_sel_word (r_cnt),
      .i_st_en    (w_st_en & (w_set == IDX_W'(s))),
      .i_we       (we_i),
      .i_wdata    (data_i),
      .i_inst_en  (w_inst_en & (w_set == IDX_W'(s))),
      .i_adv      (r_vic_valid),
      .i_line     (r_line),
      .i_inv_en   (w_inv_en & (w_set == IDX_W'(s))),
      .o_hit      (w_hit_v[s]),
      .o_hit_data (w_hdat_v[s]),
      .o_vic_way  (w_vway_v[s]),
      .o_vic_meta (w_vmeta_v[s]),
      .o_sel_meta (w_smeta_v[s]),
      .o_sel_data (w_sdat_v[s])
    );
  end

  assign w_hit      = w_hit_v[w_set];
  assign w_hit_data = w_hdat_v[w_set];
  assign w_vic_way  = w_vway_v[w_set];
  assign w_vic_meta = w_vmeta_v[w_set];
  assign w_sel_meta = w_smeta_v[w_set];
  assign w_sel_data = w_sdat_v[w_set];

  assign w_hit_now = w_idle & w_req & w_hit;
  assign w_st_en   = w_hit_now & write_i;
  assign valid_o   = w_hit_now;
  assign data_o    = (w_hit_now & read_i) ? w_hit_data : '0;
  assign busy_o    = ~w_idle;

  assign w_last     = (r_cnt == CNT_W'(N_WORDS_PER_LINE - 1));
  assign w_fl_dirty = w_sel_meta.valid & w_sel_meta.dirty;
  assign w_inst_en  = (r_state == ST_REFILL) & r_fill_done;
  assign w_inv_en   = (r_state == ST_FLUSH_WB) &
                      (~w_fl_dirty | (w_lsu_done & w_last));

  assign w_lsu_req = (r_state == ST_WB) |
                     ((r_state == ST_REFILL) & ~r_fill_done) |
                     ((r_state == ST_FLUSH_WB) & w_fl_dirty);
  assign w_lsu_we  = (r_state != ST_REFILL);

  // bus address for the current word of the active transfer
  always_comb begin
    w_lsu_adr = f_adr(r_tag, r_idx, r_cnt);
    unique case (1'b1)
      (r_state == ST_WB): w_lsu_adr = f_adr(r_vic_tag, r_idx, r_cnt);
      w_in_fl:            w_lsu_adr = f_adr(w_sel_meta.tag, r_fl_set, r_cnt);
      default: ;
    endcase
  end

  lsu u_lsu (
    .clk    (clk),
    .rstn_i (rstn_i),
    .i_req  (w_lsu_req),
    .i_we   (w_lsu_we),
    .i_sel  (4'hf),
    .i_adr  (w_lsu_adr),
    .i_wdat (w_sel_data),
    .o_done (w_lsu_done),
    .o_rdat (w_lsu_rdat),
    .wb     (wb_bus)
  );

  // miss / write-back / refill / flush sequencing
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_tag       <= '0;
      r_vic_way   <= '0;
      r_vic_tag   <= '0;
      r_vic_valid <= 1'b0;
      r_cnt       <= '0;
      r_fill_done <= 1'b0;
      r_fl_set    <= '0;
      r_fl_way    <= '0;
      r_line      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req && !w_hit) begin
            r_idx       <= w_a_idx;
            r_tag       <= w_a_tag;
            r_vic_way   <= w_vic_way;
            r_vic_tag   <= w_vic_meta.tag;
            r_vic_valid <= w_vic_meta.valid;
            r_cnt       <= '0;
            r_state     <= (w_vic_meta.valid && w_vic_meta.dirty) ?
                           ST_WB : ST_REFILL;
          end else if (flush_i && !w_req) begin
            r_fl_set <= '0;
            r_fl_way <= '0;
            r_cnt    <= '0;
            r_state  <= ST_FLUSH_WB;
          end
        end
        ST_WB: begin
          if (w_lsu_done) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_state <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (r_fill_done) begin
            r_fill_done <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_lsu_done) begin
            r_line[32*r_cnt +: 32] <= w_lsu_rdat;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_fill_done <= 1'b1;
          end
        end
        ST_FLUSH_WB: begin
          if (!w_fl_dirty) begin
            r_state <= ST_FLUSH_NEXT;
          end else if (w_lsu_done) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_state <= ST_FLUSH_NEXT;
          end
        end
        ST_FLUSH_NEXT: begin
          if (r_fl_set == IDX_W'(N_SETS - 1) &&
              r_fl_way == WAY_W'(N_WAYS - 1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_FLUSH_WB;
            if (r_fl_way == WAY_W'(N_WAYS - 1)) begin
              r_fl_way <= '0;
              r_fl_set <= r_fl_set + 1'b1;
            end else begin
              r_fl_way <= r_fl_way + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
